// File: rtl/pixel_assembler.sv
// Reassembles R, G and B channel samples into packed pixels and queues them
// in a small output FIFO with a registered head for the downstream consumer.
module pixel_assembler #(
    parameter int bitwidth = 8,
    parameter int depth    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [bitwidth-1:0]       R_data_in,
    input  logic [bitwidth-1:0]       G_data_in,
    input  logic [bitwidth-1:0]       B_data_in,
    input  logic                      R_ready_in,
    input  logic                      G_ready_in,
    input  logic                      B_ready_in,
    output logic [3*bitwidth-1:0]     pixel_out,
    output logic                      pixel_valid_out,
    input  logic                      pixel_ready_in,
    output logic [$clog2(depth):0]    fill_out,
    output logic                      overflow_out,
    output logic                      seq_error_out
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] fill_max = (aw+1)'(depth);

    localparam logic [1:0] WAIT_R = 2'd0;
    localparam logic [1:0] WAIT_G = 2'd1;
    localparam logic [1:0] WAIT_B = 2'd2;

    // Bit 2 = R, bit 1 = G, bit 0 = B throughout.
    logic [2:0] ready_vec;
    logic [2:0] prev_reg;
    logic [2:0] strobe_vec;

    assign ready_vec = {R_ready_in, G_ready_in, B_ready_in};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_strobe
            assign strobe_vec[gi] = ready_vec[gi] & ~prev_reg[gi];
        end
    endgenerate

    logic [1:0]            state_reg, state_next;
    logic [bitwidth-1:0]   r_cap_reg, r_cap_next;
    logic [bitwidth-1:0]   g_cap_reg, g_cap_next;
    logic                  push;
    logic                  seq_err_set;
    logic                  multi_hit;

    assign multi_hit = (strobe_vec[2] & strobe_vec[1]) | (strobe_vec[2] & strobe_vec[0]) |
                       (strobe_vec[1] & strobe_vec[0]);

    always_comb begin
        state_next  = state_reg;
        r_cap_next  = r_cap_reg;
        g_cap_next  = g_cap_reg;
        push        = 1'b0;
        seq_err_set = 1'b0;
        if (multi_hit) begin
            seq_err_set = 1'b1;
            state_next  = WAIT_R;
        end else if (strobe_vec[2]) begin
            // An R strobe always restarts a pixel, even when it was unexpected.
            r_cap_next  = R_data_in;
            state_next  = WAIT_G;
            seq_err_set = (state_reg != WAIT_R);
        end else if (strobe_vec[1]) begin
            if (state_reg == WAIT_G) begin
                g_cap_next = G_data_in;
                state_next = WAIT_B;
            end else begin
                seq_err_set = 1'b1;
                state_next  = WAIT_R;
            end
        end else if (strobe_vec[0]) begin
            if (state_reg == WAIT_B) begin
                push = 1'b1;
            end else begin
                seq_err_set = 1'b1;
            end
            state_next = WAIT_R;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_reg      <= '0;
            state_reg     <= WAIT_R;
            r_cap_reg     <= '0;
            g_cap_reg     <= '0;
            seq_error_out <= 1'b0;
        end else begin
            prev_reg      <= ready_vec;
            state_reg     <= state_next;
            r_cap_reg     <= r_cap_next;
            g_cap_reg     <= g_cap_next;
            seq_error_out <= seq_error_out | seq_err_set;
        end
    end

    logic [3*bitwidth-1:0] mem [depth];
    logic [aw-1:0]         wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
    logic [aw:0]           fill_reg, fill_next;
    logic [3*bitwidth-1:0] head_reg, head_next, push_data;
    logic                  pop, full, push_ok, forward;

    assign push_data  = {r_cap_reg, g_cap_reg, B_data_in};
    assign pop        = pixel_valid_out & pixel_ready_in;
    assign full       = (fill_reg == fill_max);
    assign push_ok    = push & (~full | pop);
    assign rd_ptr_inc = rd_ptr_reg + aw'(1);

    // The new pixel becomes the head directly only when nothing older remains.
    assign forward = push_ok & ((fill_reg == '0) | ((fill_reg == (aw+1)'(1)) & pop));

    always_comb begin
        fill_next = fill_reg;
        if (push_ok & ~pop) begin
            fill_next = fill_reg + (aw+1)'(1);
        end else if (pop & ~push_ok) begin
            fill_next = fill_reg - (aw+1)'(1);
        end
        head_next = head_reg;
        if (forward) begin
            head_next = push_data;
        end else if (pop) begin
            head_next = mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            head_reg     <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + aw'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            fill_reg     <= fill_next;
            head_reg     <= head_next;
            overflow_out <= overflow_out | (push & full & ~pop);
        end
    end

    assign pixel_out       = head_reg;
    assign pixel_valid_out = (fill_reg != '0);
    assign fill_out        = fill_reg;

endmodule

// File: tb/tb_pixel_assembler.sv
// Directed bench for pixel_assembler: channel sequencing, FIFO back-pressure,
// overflow, sticky flags and asynchronous reset.
module tb_pixel_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  r_d = '0, g_d = '0, b_d = '0;
    logic        r_rdy = 1'b0, g_rdy = 1'b0, b_rdy = 1'b0;
    logic        pixel_ready = 1'b0;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [2:0]  fill;
    logic        overflow;
    logic        seq_error;

    int checks  = 0;
    int errors  = 0;
    int pop_cnt = 0;
    int p0;

    pixel_assembler #(.bitwidth(8), .depth(4)) dut (
        .clock           (clk),
        .reset           (rst),
        .R_data_in       (r_d),
        .G_data_in       (g_d),
        .B_data_in       (b_d),
        .R_ready_in      (r_rdy),
        .G_ready_in      (g_rdy),
        .B_ready_in      (b_rdy),
        .pixel_out       (pixel),
        .pixel_valid_out (pixel_valid),
        .pixel_ready_in  (pixel_ready),
        .fill_out        (fill),
        .overflow_out    (overflow),
        .seq_error_out   (seq_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pixel_valid && pixel_ready) pop_cnt <= pop_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("check %s ok: %h", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pix(input logic [7:0] base, input int i);
        logic [7:0] k;
        k = 8'(i);
        return {base + k, base + 8'h10 + k, base + 8'h20 + k};
    endfunction

    // Strobes R, G, B on consecutive cycles; returns just after the B edge.
    task automatic send_pixel(input logic [23:0] p, input bit keep_b, input bit pop_on_b);
        r_rdy = 1'b1; r_d = p[23:16];
        tick;
        r_rdy = 1'b0; g_rdy = 1'b1; g_d = p[15:8];
        tick;
        g_rdy = 1'b0; b_rdy = 1'b1; b_d = p[7:0];
        if (pop_on_b) pixel_ready = 1'b1;
        tick;
        if (pop_on_b) pixel_ready = 1'b0;
        if (!keep_b) b_rdy = 1'b0;
    endtask

    task automatic pulse(input int ch, input logic [7:0] d);
        case (ch)
            0: begin r_rdy = 1'b1; r_d = d; end
            1: begin g_rdy = 1'b1; g_d = d; end
            default: begin b_rdy = 1'b1; b_d = d; end
        endcase
        tick;
        r_rdy = 1'b0; g_rdy = 1'b0; b_rdy = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_valid", pixel_valid, 0);
        check("reset_fill", fill, 0);
        check("reset_pixel", pixel, 0);
        check("reset_ovf", overflow, 0);
        check("reset_seq", seq_error, 0);
        tick;
        tick;
        rst = 1'b0;

        // Single pixel, one cycle latency, popped on the next edge
        pixel_ready = 1'b1;
        send_pixel(24'h112233, 1'b0, 1'b0);
        check("p1_valid", pixel_valid, 1);
        check("p1_pixel", pixel, 24'h112233);
        tick;
        check("p1_gone", pixel_valid, 0);

        // B level held high counts once
        p0 = pop_cnt;
        send_pixel(24'h112233, 1'b1, 1'b0);
        check("hold_pixel_a", pixel, 24'h112233);
        tick;
        check("hold_no_dup", pixel_valid, 0);
        b_rdy = 1'b0;
        send_pixel(24'h445566, 1'b0, 1'b0);
        check("hold_pixel_b", pixel, 24'h445566);
        tick;
        check("hold_pop_count", pop_cnt - p0, 2);
        check("hold_seq", seq_error, 0);

        // Full FIFO with push and pop in the same cycle
        pixel_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_pixel(pix(8'h10, i), 1'b0, 1'b0);
        check("fullpop_fill4", fill, 4);
        send_pixel(pix(8'h10, 4), 1'b0, 1'b1);
        check("fullpop_fill", fill, 4);
        check("fullpop_ovf", overflow, 0);
        pixel_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check("fullpop_drain_valid", pixel_valid, 1);
            check("fullpop_drain_pixel", pixel, pix(8'h10, k));
            tick;
        end
        check("fullpop_empty", fill, 0);
        pixel_ready = 1'b0;

        // Overflow: fifth pixel dropped
        for (int i = 0; i < 5; i++) begin
            send_pixel(pix(8'hA0, i), 1'b0, 1'b0);
            if (i == 3) check("ovf_fill_before", {fill, overflow}, {3'd4, 1'b0});
        end
        check("ovf_fill", fill, 4);
        check("ovf_flag", overflow, 1);
        pixel_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain_pixel", pixel, pix(8'hA0, k));
            tick;
        end
        check("ovf_empty_valid", pixel_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Out-of-order strobes
        rst = 1'b1;
        #1;
        check("rst2_ovf", overflow, 0);
        tick;
        rst = 1'b0;
        p0 = pop_cnt;
        pulse(0, 8'h77);
        check("seq_after_r", seq_error, 0);
        pulse(2, 8'h99);
        check("seq_after_b", seq_error, 1);
        check("seq_no_pixel_1", pixel_valid, 0);
        pulse(1, 8'h88);
        check("seq_no_pixel_2", pixel_valid, 0);
        pulse(2, 8'h99);
        check("seq_no_pixel_3", pixel_valid, 0);
        send_pixel(24'h123456, 1'b0, 1'b0);
        check("seq_fresh_pixel", pixel, 24'h123456);
        tick;
        check("seq_pop_count", pop_cnt - p0, 1);
        check("seq_sticky", seq_error, 1);

        // Asynchronous reset in WAIT_B with two pixels queued
        pixel_ready = 1'b0;
        send_pixel(24'h010203, 1'b0, 1'b0);
        send_pixel(24'h040506, 1'b0, 1'b0);
        pulse(0, 8'h0A);
        pulse(1, 8'h0B);
        check("pre_rst_fill", fill, 2);
        r_rdy = 1'b1; r_d = 8'hAB;
        rst = 1'b1;
        #1;
        check("arst_valid", pixel_valid, 0);
        check("arst_fill", fill, 0);
        check("arst_pixel", pixel, 0);
        check("arst_seq", seq_error, 0);
        tick;
        rst = 1'b0;
        p0 = pop_cnt;
        pixel_ready = 1'b1;
        tick;
        r_rdy = 1'b0; g_rdy = 1'b1; g_d = 8'hCD;
        tick;
        g_rdy = 1'b0; b_rdy = 1'b1; b_d = 8'hEF;
        tick;
        b_rdy = 1'b0;
        check("post_rst_pixel", pixel, 24'hABCDEF);
        check("post_rst_valid", pixel_valid, 1);
        tick;
        check("post_rst_empty", fill, 0);
        check("post_rst_pops", pop_cnt - p0, 1);
        check("post_rst_seq", seq_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
